// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start-bit qualification, mid-bit sampling, frame assembly
// and ready/parity/framing/overrun status for the host read handshake.
module uart_rx_ctrl #(
    parameter int BT_W = 19
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    input  logic [BT_W-1:0] k,
    input  logic            eight,
    input  logic            p_en,
    input  logic            ohel,
    input  logic            bc_done,
    input  logic            rd,
    output logic [1:0]      bc_sel,
    output logic [7:0]      rx_data,
    output logic            rx_rdy,
    output logic            perr,
    output logic            ferr,
    output logic            ovf
);
    // state   | meaning
    // S_IDLE  | line idle, bit-time counter cleared, waiting for rxs low
    // S_START | half a bit time to re-sample the start bit
    // S_DATA  | sample data/parity/stop each bit time until bc_done
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA} state_t;

    state_t          state_q, state_d;
    logic            sync_q, rxs_q;
    logic [BT_W-1:0] cnt_q, cnt_d, cnt_inc, target;
    logic            btu;
    logic [9:0]      sr_q, sr_d, aligned;
    logic            eight_q, eight_d, p_en_q, p_en_d, ohel_q, ohel_d;
    logic [7:0]      rx_data_q, rx_data_d, frame_data;
    logic            rx_rdy_q, rx_rdy_d, perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
    logic [3:0]      n_bits, par_idx, stop_idx;
    logic            par_bit, stop_bit, done;

    // The first data bit lands at position 11-N after N-1 shifts; realign to bit 0.
    always_comb begin
        n_bits     = 4'd9 + {3'b000, eight_q} + {3'b000, p_en_q};
        aligned    = sr_q >> (4'd11 - n_bits);
        par_idx    = n_bits - 4'd3;
        stop_idx   = n_bits - 4'd2;
        par_bit    = aligned[par_idx];
        stop_bit   = aligned[stop_idx];
        frame_data = {eight_q & aligned[7], aligned[6:0]};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        eight_d   = eight_q;
        p_en_d    = p_en_q;
        ohel_d    = ohel_q;
        rx_data_d = rx_data_q;
        rx_rdy_d  = rx_rdy_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        ovf_d     = ovf_q;
        bc_sel    = 2'b00;
        done      = 1'b0;
        cnt_inc   = cnt_q + BT_W'(1);
        target    = (state_q == S_START) ? (k >> 1) : k;
        btu       = (state_q != S_IDLE) && (cnt_inc == target);

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs_q) begin
                    state_d = S_START;
                    eight_d = eight;
                    p_en_d  = p_en;
                    ohel_d  = ohel;
                end
            end
            S_START: begin
                cnt_d = btu ? '0 : cnt_inc;
                if (btu) begin
                    if (!rxs_q) begin
                        bc_sel  = 2'b11;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (bc_done) begin
                    bc_sel  = 2'b10;
                    done    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (btu) begin
                    bc_sel = 2'b11;
                    cnt_d  = '0;
                    sr_d   = {rxs_q, sr_q[9:1]};
                end else begin
                    bc_sel = 2'b10;
                    cnt_d  = cnt_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Completion takes priority over a coincident read.
        if (done) begin
            rx_data_d = frame_data;
            rx_rdy_d  = 1'b1;
            ferr_d    = !stop_bit;
            perr_d    = p_en_q & ((^frame_data ^ par_bit) != ohel_q);
            ovf_d     = rx_rdy_q & !rd;
        end else if (rd) begin
            rx_rdy_d = 1'b0;
            perr_d   = 1'b0;
            ferr_d   = 1'b0;
            ovf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            sync_q    <= 1'b1;
            rxs_q     <= 1'b1;
            cnt_q     <= '0;
            sr_q      <= '0;
            eight_q   <= 1'b0;
            p_en_q    <= 1'b0;
            ohel_q    <= 1'b0;
            rx_data_q <= '0;
            rx_rdy_q  <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= rx;
            rxs_q     <= sync_q;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            eight_q   <= eight_d;
            p_en_q    <= p_en_d;
            ohel_q    <= ohel_d;
            rx_data_q <= rx_data_d;
            rx_rdy_q  <= rx_rdy_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
        end
    end

    assign rx_data = rx_data_q;
    assign rx_rdy  = rx_rdy_q;
    assign perr    = perr_q;
    assign ferr    = ferr_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: serial frames are generated bit by bit, results are predicted
// from the frame contents and the end-to-end latency formula.
module tb_uart_rx_ctrl;
    localparam int BT_W = 19;

    logic            clk = 1'b0;
    logic            rst, rx, eight, p_en, ohel, bc_done, rd;
    logic [BT_W-1:0] k;
    logic [1:0]      bc_sel;
    logic [7:0]      rx_data;
    logic            rx_rdy, perr, ferr, ovf;
    logic [3:0]      bc_cnt;

    int checks = 0;
    int errors = 0;
    bit model_rdy = 1'b0;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.BT_W(BT_W)) dut (
        .clk(clk), .rst(rst), .rx(rx), .k(k), .eight(eight), .p_en(p_en), .ohel(ohel),
        .bc_done(bc_done), .rd(rd), .bc_sel(bc_sel), .rx_data(rx_data), .rx_rdy(rx_rdy),
        .perr(perr), .ferr(ferr), .ovf(ovf)
    );

    // External Rx bit counter, reading the live configuration pins.
    always @(posedge clk or negedge rst) begin
        if (!rst) bc_cnt <= 4'd0;
        else case (bc_sel)
            2'b00:   bc_cnt <= 4'd0;
            2'b11:   bc_cnt <= bc_cnt + 4'd1;
            default: bc_cnt <= bc_cnt;
        endcase
    end
    assign bc_done = (int'(bc_cnt) == 9 + int'(eight) + int'(p_en));

    typedef struct {
        int         kk;
        bit         e8, pe, od;
        logic [7:0] b;
        bit         bad_par, stop_b, rd_done, rd_after;
        logic [7:0] exp_d;
        bit         exp_pe, exp_fe, exp_ov;
        string      nm;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; that edge is E0 and rx falls for edge E0+1.
    task automatic run_frame(input int kk, input bit e8, input bit pe, input bit od,
                             input logic [7:0] b, input bit bad_par, input bit stop_b,
                             input bit rd_done, input bit rd_after, input logic [7:0] exp_d,
                             input bit exp_pe, input bit exp_fe, input bit exp_ov,
                             input string nm);
        int n, lat, tot, idx;
        bit lv[11];
        bit pbit;
        n    = 9 + int'(e8) + int'(pe);
        pbit = (e8 ? ^b : ^b[6:0]) ^ od ^ bad_par;
        lv[0] = 1'b0;
        for (int i = 0; i < 7 + int'(e8); i++) lv[1+i] = b[i];
        idx = 8 + int'(e8);
        if (pe) begin
            lv[idx] = pbit;
            idx++;
        end
        lv[idx] = stop_b;
        k = BT_W'(kk); eight = e8; p_en = pe; ohel = od;
        lat = 4 + kk / 2 + (n - 1) * kk;
        tot = n * kk + 2 * kk + 4;
        for (int c = 0; c < tot; c++) begin
            rx = (c < n * kk) ? lv[c / kk] : 1'b1;
            rd = rd_done && (c == lat - 1);
            @(negedge clk);
            if (c == lat - 1) chk({nm, "_rdy_early"}, rx_rdy, model_rdy);
            if (c == lat) begin
                chk({nm, "_rdy"},  rx_rdy, 1);
                chk({nm, "_data"}, rx_data, exp_d);
                chk({nm, "_perr"}, perr, exp_pe);
                chk({nm, "_ferr"}, ferr, exp_fe);
                chk({nm, "_ovf"},  ovf, exp_ov);
            end
            @(posedge clk); #1;
        end
        rd = 1'b0;
        model_rdy = 1'b1;
        if (rd_after) begin
            rd = 1'b1;
            @(posedge clk); #1;
            rd = 1'b0;
            @(negedge clk);
            chk({nm, "_rd_rdy"},  rx_rdy, 0);
            chk({nm, "_rd_perr"}, perr, 0);
            chk({nm, "_rd_ferr"}, ferr, 0);
            chk({nm, "_rd_ovf"},  ovf, 0);
            chk({nm, "_rd_data"}, rx_data, exp_d);
            @(posedge clk); #1;
            model_rdy = 1'b0;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit saw11;
        vt[0]  = '{16, 1, 0, 0, 8'hA5, 0, 1, 0, 1, 8'hA5, 0, 0, 0, "8n1_a5"};
        vt[1]  = '{16, 0, 1, 0, 8'h55, 1, 1, 0, 1, 8'h55, 1, 0, 0, "7e1_bad"};
        vt[2]  = '{16, 0, 1, 0, 8'h55, 0, 1, 0, 1, 8'h55, 0, 0, 0, "7e1_good"};
        vt[3]  = '{16, 1, 1, 1, 8'h55, 1, 1, 0, 1, 8'h55, 1, 0, 0, "8o1_bad"};
        vt[4]  = '{16, 1, 1, 1, 8'h55, 0, 1, 0, 1, 8'h55, 0, 0, 0, "8o1_good"};
        vt[5]  = '{8,  1, 0, 0, 8'h3C, 0, 0, 0, 1, 8'h3C, 0, 1, 0, "ferr"};
        vt[6]  = '{8,  1, 0, 0, 8'h11, 0, 1, 0, 0, 8'h11, 0, 0, 0, "ovr1"};
        vt[7]  = '{8,  1, 0, 0, 8'h22, 0, 1, 0, 0, 8'h22, 0, 0, 1, "ovr2"};
        vt[8]  = '{8,  1, 0, 0, 8'h33, 0, 1, 1, 1, 8'h33, 0, 0, 0, "ovr3_rd"};
        vt[9]  = '{2,  0, 0, 0, 8'hFF, 0, 1, 0, 1, 8'h7F, 0, 0, 0, "7n1_k2"};
        vt[10] = '{3,  1, 1, 0, 8'h80, 0, 1, 0, 1, 8'h80, 0, 0, 0, "8e1_k3"};

        rst = 1'b0; rx = 1'b1; rd = 1'b0; k = BT_W'(16); eight = 1'b1; p_en = 1'b0; ohel = 1'b0;
        #12;
        chk("rst_bc_sel", bc_sel, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_rdy", rx_rdy, 0);
        chk("rst_perr", perr, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_ovf", ovf, 0);
        #11 rst = 1'b1;
        @(posedge clk); #1;

        // False start: 4-cycle low glitch must never advance the bit counter.
        saw11 = 1'b0;
        for (int c = 0; c < 40; c++) begin
            rx = (c < 4) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (bc_sel == 2'b11) saw11 = 1'b1;
            @(posedge clk); #1;
        end
        chk("fs_no_incr", saw11, 0);
        chk("fs_rdy", rx_rdy, 0);
        chk("fs_bc_sel", bc_sel, 0);

        for (int i = 0; i < 11; i++)
            run_frame(vt[i].kk, vt[i].e8, vt[i].pe, vt[i].od, vt[i].b, vt[i].bad_par,
                      vt[i].stop_b, vt[i].rd_done, vt[i].rd_after, vt[i].exp_d,
                      vt[i].exp_pe, vt[i].exp_fe, vt[i].exp_ov, vt[i].nm);

        // Reset in the middle of the 4th data bit with a byte already pending.
        run_frame(16, 1, 0, 0, 8'h5A, 0, 0, 0, 0, 8'h5A, 0, 1, 0, "pre_rst");
        k = BT_W'(16); eight = 1'b1; p_en = 1'b0; ohel = 1'b0;
        for (int c = 0; c < 72; c++) begin
            rx = (c < 16) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("rst_mid_pre_bc_sel", bc_sel, 2'b10);
        chk("rst_mid_pre_rdy", rx_rdy, 1);
        #1 rst = 1'b0;
        #1;
        chk("rst_mid_bc_sel", bc_sel, 0);
        chk("rst_mid_data", rx_data, 0);
        chk("rst_mid_rdy", rx_rdy, 0);
        chk("rst_mid_perr", perr, 0);
        chk("rst_mid_ferr", ferr, 0);
        chk("rst_mid_ovf", ovf, 0);
        rx = 1'b1;
        model_rdy = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        run_frame(16, 1, 0, 0, 8'h3C, 0, 1, 0, 1, 8'h3C, 0, 0, 0, "post_rst");

        // Random frames against the frame-level model.
        for (int i = 0; i < 20; i++) begin
            int kk;
            bit e8, pe, od, bad, stp, rdd, rda;
            logic [7:0] b, ed;
            kk  = int'($urandom_range(2, 12));
            e8  = 1'($urandom_range(0, 1));
            pe  = 1'($urandom_range(0, 1));
            od  = 1'($urandom_range(0, 1));
            bad = 1'($urandom_range(0, 1));
            stp = ($urandom_range(0, 3) != 0);
            rdd = ($urandom_range(0, 3) == 0);
            rda = 1'($urandom_range(0, 1));
            b   = 8'($urandom_range(0, 255));
            ed  = e8 ? b : {1'b0, b[6:0]};
            run_frame(kk, e8, pe, od, b, bad, stp, rdd, rda, ed, pe & bad, !stp,
                      model_rdy & !rdd, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side sequencer for the UART. It owns the start-bit/bit-time state machine, drives the select of the external Rx bit counter, samples the serial line at mid-bit, and assembles the frame into a data byte with parity and framing status. It sits between the pin-level `rx` input and the TSI/register interface, which reads the byte through a ready/read handshake.

## Interface
- `BT_W`, default 19: width of the baud divisor and the internal bit-time counter.
- `clk  in  1`: system clock; all state updates on the rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `rx  in  1`: asynchronous serial input; idles high.
- `k  in  BT_W`: clocks per bit time; legal range 2 and up.
- `eight  in  1`: 1 selects 8 data bits, 0 selects 7.
- `p_en  in  1`: parity enable.
- `ohel  in  1`: parity sense; 1 is odd, 0 is even.
- `bc_done  in  1`: done output of the external Rx bit counter.
- `rd  in  1`: single-cycle read strobe from the host.
- `bc_sel  out  2`: select for the external bit counter. 00 clears it, 10 holds it, 11 increments it.
- `rx_data  out  8`: received byte; bit 7 is forced to 0 when `eight`=0.
- `rx_rdy  out  1`: a byte is available.
- `perr  out  1`: parity error. `ferr  out  1`: framing error. `ovf  out  1`: overrun.

## Operation
- **Input synchronizer.** `rx` passes through a 2-flop synchronizer, reset to 1. All logic uses the synchronized value `rxs`.
- **IDLE** (reset state).
  - `bc_sel`=00; bit-time counter held at 0.
  - `rxs`=0 moves to START and latches `eight`, `p_en` and `ohel`.
- **START.** Target = `k>>1`.
  - At btu with `rxs`=0: `bc_sel`=11 and go to DATA.
  - At btu with `rxs`=1: false start; go to IDLE with no status change.
- **DATA.** Target = `k`.
  - Each btu: `bc_sel`=11, and `rxs` shifts into the MSB of a 10-bit right-shifting register.
  - Otherwise `bc_sel`=10.
  - `bc_done`=1 completes the frame and moves to IDLE.
- **Bit-time counter.**
  - Counts up every cycle in START and DATA.
  - btu is asserted for one cycle when the count equals the target; the counter clears in that same cycle.
- **Frame length.** N = 9 + `eight` + `p_en`. This is start + data + parity + stop, so the external counter reaches N at the stop-bit sample.
- **Data alignment at completion.**
  - Aligned value a = shift register >> (11 − N).
  - Data is a[6:0] plus a[7] when `eight`=1.
  - Parity bit is a[N−3] (when `p_en`=1); stop bit is a[N−2].
- **Frame completion** (single cycle):
  - Loads `rx_data`.
  - Sets `rx_rdy`.
  - `ferr` = !stop.
  - `perr` = `p_en` & (XOR of data bits and parity bit ≠ `ohel`).
  - `ovf` = `rx_rdy` & !`rd`.
- **Clearing status.**
  - `rd` clears `rx_rdy`, `perr`, `ferr` and `ovf`.
  - If `rd` and completion occur in the same cycle, completion wins: `rx_rdy` stays 1, the new status is loaded, and `ovf`=0.
- **Overrun.** On overrun, `rx_data` is overwritten with the new byte.
- **Configuration changes.** The block uses its latched copies of `eight`, `p_en` and `ohel`. Configuration must not change mid-frame, because the external counter reads the live pins.

## Timing
- **Reset values.**
  - `bc_sel`=00, `rx_data`=0x00.
  - `rx_rdy`, `perr`, `ferr`, `ovf` all 0.
  - State IDLE; synchronizer holds 1.
- **Start detection.** An `rx` falling edge is seen in IDLE 2 clocks later (synchronizer latency).
- **Start-bit btu.** Occurs `k>>1` cycles after entering START.
- **Data-bit btus.** Each follows the previous one by `k` cycles.
- **Completion.** `bc_done` rises the cycle after the Nth increment. Completion happens in that cycle, and `rx_rdy` is visible on the next edge.
- **End-to-end latency.** From the `rx` falling edge to `rx_rdy`=1 is 2 + (`k>>1`) + (N−1)·`k` + 2 clocks.
- **Return to idle.** IDLE is re-entered at completion. A new start can be detected immediately; there is no dead cycle requirement beyond the stop-bit sample.
- **Reset mid-frame.** Asynchronous; all outputs return to reset values at once, and any partial frame is discarded.
- **Status outputs.** Registered and stable between completion and `rd`.

## Test plan
- **8N1 byte with `k`=16:** send 0xA5 with a good stop bit → `rx_data`=0xA5, `rx_rdy`=1 at the computed latency; `perr`=0, `ferr`=0.
- **7E1 and 8O1:** send 0x55 with a wrong parity bit → `perr`=1 and correct data. Then send 0x55 with a correct parity bit → `perr`=0.
- **False start:** a 4-cycle low glitch with `k`=16 → returns to IDLE, `rx_rdy` stays 0, and `bc_sel` shows no 11.
- **Framing error:** stop bit held low → `ferr`=1 and data still loaded.
- **Overrun:** two frames with no `rd` → `ovf`=1 and `rx_data` = second byte. Assert `rd` in the exact completion cycle of a third frame → `rx_rdy`=1 and `ovf`=0.
- **Reset mid-frame:** assert `rst` low during the 4th data bit → all outputs 0 immediately. After release, a clean frame of 0x3C is received correctly.
